// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS subset pipeline: opcodes, ALU op codes,
// forward-select encodings and the decoded control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   branch;
    logic   alusrc;
    logic   regdst;
    aluop_e aluop;
  } ctrl_t;

  // The instruction now in ID/EX will sit in EX/MEM when this one reaches EX, hence 10 first.
  function automatic fwd_e fwd_sel(input logic       ex_rw,
                                   input logic [4:0] ex_dst,
                                   input logic       mem_rw,
                                   input logic [4:0] mem_dst,
                                   input logic [4:0] src);
    if (ex_rw && (ex_dst == src))
      return FWD_EXMEM;
    else if (mem_rw && (mem_dst != 5'd0) && (mem_dst == src))
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational main decoder: opcode to control bundle, plus whether rt is a
// source operand and whether the opcode is outside the supported subset.
module main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rt,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    uses_rt = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.aluop    = ALUOP_FUNCT;
        uses_rt       = 1'b1;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
        uses_rt       = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALUOP_SUB;
        uses_rt     = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register: register-file addressing, control decode,
// load-use hazard stall, and precomputed forward selects for EX.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16,
  parameter logic [31:0] RESET_PC4   = 32'h0000_0004
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_id_valid,
  input  logic [31:0]            if_id_instr,
  input  logic [31:0]            if_id_pc4,
  output logic [4:0]             rn1,
  output logic [4:0]             rn2,
  input  logic [31:0]            rd1,
  input  logic [31:0]            rd2,
  input  logic                   mem_regwrite,
  input  logic [4:0]             mem_dst,
  input  logic                   flush,
  output logic                   stall,
  output logic                   ex_valid,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic                   ex_memtoreg,
  output logic                   ex_branch,
  output logic                   ex_alusrc,
  output logic [1:0]             ex_aluop,
  output logic [4:0]             ex_dst,
  output logic [31:0]            ex_a,
  output logic [31:0]            ex_b,
  output logic [31:0]            ex_imm,
  output logic [31:0]            ex_pc4,
  output logic [5:0]             ex_funct,
  output logic [1:0]             ex_fwd_a,
  output logic [1:0]             ex_fwd_b,
  output logic                   illegal_op,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [4:0] rs, rt, rd, dst;
  ctrl_t      dec_ctrl;
  logic       uses_rt;
  logic       illegal;
  logic       hazard;
  logic       squash;
  fwd_e       fwd_a_nxt, fwd_b_nxt;

  assign rs  = if_id_instr[25:21];
  assign rt  = if_id_instr[20:16];
  assign rd  = if_id_instr[15:11];
  assign rn1 = rs;
  assign rn2 = rt;

  main_decoder u_main_decoder (
    .opcode  (if_id_instr[31:26]),
    .ctrl    (dec_ctrl),
    .uses_rt (uses_rt),
    .illegal (illegal)
  );

  assign dst = dec_ctrl.regdst ? rd : rt;

  assign hazard = if_id_valid && ex_valid && ex_memread && (ex_dst != 5'd0) && !flush &&
                  ((ex_dst == rs) || ((ex_dst == rt) && uses_rt));
  assign stall  = hazard;
  assign squash = flush || hazard || !if_id_valid || illegal;

  assign fwd_a_nxt = fwd_sel(ex_regwrite, ex_dst, mem_regwrite, mem_dst, rs);
  assign fwd_b_nxt = fwd_sel(ex_regwrite, ex_dst, mem_regwrite, mem_dst, rt);

  // Control is cleared for any bubble; data fields are held during a stall so the
  // stalled load's destination stays visible for one more cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_branch   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_dst      <= 5'd0;
      ex_a        <= 32'd0;
      ex_b        <= 32'd0;
      ex_imm      <= 32'd0;
      ex_pc4      <= RESET_PC4;
      ex_funct    <= 6'd0;
      ex_fwd_a    <= 2'b00;
      ex_fwd_b    <= 2'b00;
      illegal_op  <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      ex_valid    <= !squash;
      ex_regwrite <= !squash && dec_ctrl.regwrite && (dst != 5'd0);
      ex_memread  <= !squash && dec_ctrl.memread;
      ex_memwrite <= !squash && dec_ctrl.memwrite;
      ex_memtoreg <= !squash && dec_ctrl.memtoreg;
      ex_branch   <= !squash && dec_ctrl.branch;
      ex_alusrc   <= !squash && dec_ctrl.alusrc;
      ex_aluop    <= squash ? 2'b00 : dec_ctrl.aluop;
      if (!hazard) begin
        ex_dst   <= dst;
        ex_a     <= rd1;
        ex_b     <= rd2;
        ex_imm   <= {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        ex_pc4   <= if_id_pc4;
        ex_funct <= if_id_instr[5:0];
      end
      ex_fwd_a   <= fwd_a_nxt;
      ex_fwd_b   <= fwd_b_nxt;
      illegal_op <= if_id_valid && illegal && !flush && !hazard;
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode stage plus ID/EX pipeline register for the 5-stage MIPS subset pipeline. It sits directly downstream of the register file.
- Drives the two read addresses from the IF/ID instruction.
- Captures RD1/RD2, decodes control, sign-extends the immediate and detects load-use hazards.
- Registers everything plus precomputed forwarding selects for the EX stage.

Parameters:
STALL_CNT_W, 16, width of saturating load-use stall counter
RESET_PC4, 32'h0000_0004, reset value of ex_pc4

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
if_id_valid  in  1  IF/ID holds a real instruction
if_id_instr  in  32  instruction word
if_id_pc4  in  32  PC+4 of that instruction
rn1  out  5  reg file read addr 1 = if_id_instr[25:21] (combinational)
rn2  out  5  reg file read addr 2 = if_id_instr[20:16] (combinational)
rd1  in  32  reg file read data 1
rd2  in  32  reg file read data 2
mem_regwrite  in  1  EX/MEM instruction writes a register
mem_dst  in  5  EX/MEM destination register
flush  in  1  taken branch resolved in EX; squash ID
stall  out  1  hold PC and IF/ID (combinational)
ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc  out  1 each  registered control
ex_aluop  out  2  00 add, 01 sub, 10 funct
ex_dst  out  5  resolved destination (rd or rt)
ex_a, ex_b  out  32  operand values from rd1/rd2
ex_imm  out  32  sign-extended instr[15:0]
ex_pc4  out  32  registered if_id_pc4
ex_funct  out  6  instr[5:0]
ex_fwd_a, ex_fwd_b  out  2  00 reg file, 10 from EX/MEM, 01 from MEM/WB
illegal_op  out  1  one-cycle pulse, registered
stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n=0):
  - All ex_* control bits, ex_valid, ex_dst, ex_a, ex_b, ex_imm, ex_funct and ex_fwd_* = 0.
  - ex_pc4 = RESET_PC4; illegal_op = 0; stall_cnt = 0.
  - stall is combinational and therefore reads 0 after reset.
- Latency: one cycle. Values present in ID at posedge N appear on ex_* after posedge N.
- Decode, by opcode instr[31:26]:
  - 000000 R-type: regwrite, dst=rd, aluop=10, uses_rt.
  - 100011 lw: regwrite, memread, memtoreg, alusrc, dst=rt, aluop=00.
  - 101011 sw: memwrite, alusrc, aluop=00, uses_rt.
  - 000100 beq: branch, aluop=01, uses_rt.
  - 001000 addi: regwrite, alusrc, dst=rt, aluop=00.
  - Any other opcode with if_id_valid: bubble is loaded and illegal_op pulses for 1 cycle.
- ex_regwrite is forced 0 when the resolved dst is 0; 32'h0 therefore acts as a NOP.
- Load-use hazard: stall=1 when all of the following hold:
  - if_id_valid, ex_valid, ex_memread, ex_dst!=0 and flush=0;
  - ex_dst==rs, or (ex_dst==rt and uses_rt).
- On stall: a bubble is loaded (ex_valid and all control=0; data fields don't-care but held); stall_cnt increments, saturating at all-ones.
- Flush has priority over stall and decode: a bubble is loaded and stall is forced 0.
- if_id_valid=0: bubble is loaded.
- Forward selects, computed in ID and registered; rs shown, rt/ex_fwd_b identical:
  - 10 if ex_regwrite and ex_dst==rs (the current ID/EX instruction moves to EX/MEM).
  - else 01 if mem_regwrite, mem_dst!=0 and mem_dst==rs.
  - else 00.
- The reg file writes on negedge, so a WB-stage producer is already visible on rd1/rd2 at posedge; no third forward source exists.
- Selects are registered even for bubbles and ignored when ex_valid=0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - ALUOP_ADD/SUB/FUNCT;
  - FWD_RF/FWD_EXMEM/FWD_MEMWB;
  - a ctrl_t bundle of the control bits.
- Sub-module: main_decoder, a combinational opcode to ctrl_t plus uses_rt and illegal.
- Hazard detection, forward-select logic and the pipeline register stay in id_ex_stage.

Test Plan:
- addi $8,$0,5 (0x20080005), pc4=0x104 -> next cycle ex_regwrite=1, alusrc=1, ex_dst=8, ex_imm=5, ex_pc4=0x104, fwd 00.
- lw $9,0($8) then add $10,$9,$9 -> stall=1 for exactly one cycle, bubble (ex_valid=0), stall_cnt=1; add then issues with ex_fwd_a=ex_fwd_b=01.
- add $3,$1,$2 followed by sub $4,$3,$3 -> sub gets ex_fwd_a=ex_fwd_b=10; with one NOP between them -> both 01 (mem_regwrite=1, mem_dst=3).
- Same cycle as a load-use condition, flush=1 -> stall=0, bubble loaded, stall_cnt unchanged.
- Opcode 6'b111111, valid -> illegal_op high one cycle, ex_valid=0; instr 0x00000000 -> ex_valid=1, ex_regwrite=0.
- Assert rst_n low mid-stream with stall active -> all outputs at reset values immediately (before next clk edge), ex_pc4=0x4, stall_cnt=0.
